// File: rtl/btn_pulse_array.sv
// N-channel button conditioner: 2-flop sync, debounce, and press/release/repeat pulse FSM per channel.
// Raw inputs are active-low; all outputs are registered and active-high.
module btn_pulse_array #(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_DLY   = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_BTN-1:0] b_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] b_press,
    output logic [N_BTN-1:0] b_rpt,
    output logic [N_BTN-1:0] b_release,
    output logic [N_BTN-1:0] b_held
);

    // A single-cycle debounce still needs a 1-bit counter to stay legal.
    localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_RPT  = 2'd2;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        // Sync flops carry the raw (active-low) level, so 1 means released.
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             s;
        logic             db_q, db_d;
        logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
        logic [1:0]       state_q, state_d;
        logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic             fire_press, fire_rpt, fire_rel;
        logic             press_q, press_d;
        logic             rpt_q, rpt_d;
        logic             release_q, release_d;
        logic             held_q, held_d;

        assign s = ~sync2_q;

        always_comb begin
            sync1_d  = b_in[g];
            sync2_d  = sync1_q;
            db_d     = db_q;
            db_cnt_d = db_cnt_q;
            if (s == db_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_d     = s;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Release is checked first so it wins over a repeat expiring in the same cycle.
        always_comb begin
            state_d    = state_q;
            rpt_cnt_d  = rpt_cnt_q;
            fire_press = 1'b0;
            fire_rpt   = 1'b0;
            fire_rel   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rpt_cnt_d = '0;
                    if (db_q) begin
                        state_d    = ST_HELD;
                        fire_press = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!db_q) begin
                        state_d   = ST_IDLE;
                        fire_rel  = 1'b1;
                        rpt_cnt_d = '0;
                    end else if (repeat_en[g] && rpt_cnt_q == DLY_LAST) begin
                        state_d    = ST_RPT;
                        fire_press = 1'b1;
                        fire_rpt   = 1'b1;
                        rpt_cnt_d  = '0;
                    end else if (repeat_en[g]) begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end else begin
                        rpt_cnt_d = '0;
                    end
                end
                ST_RPT: begin
                    if (!db_q) begin
                        state_d   = ST_IDLE;
                        fire_rel  = 1'b1;
                        rpt_cnt_d = '0;
                    end else if (!repeat_en[g]) begin
                        state_d   = ST_HELD;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == RATE_LAST) begin
                        fire_press = 1'b1;
                        fire_rpt   = 1'b1;
                        rpt_cnt_d  = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        // Pulses are dropped while en is low; state keeps advancing regardless.
        always_comb begin
            press_d   = fire_press & en;
            rpt_d     = fire_rpt & en;
            release_d = fire_rel & en;
            held_d    = db_q;
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                db_q      <= 1'b0;
                db_cnt_q  <= '0;
                state_q   <= ST_IDLE;
                rpt_cnt_q <= '0;
                press_q   <= 1'b0;
                rpt_q     <= 1'b0;
                release_q <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                db_q      <= db_d;
                db_cnt_q  <= db_cnt_d;
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
                press_q   <= press_d;
                rpt_q     <= rpt_d;
                release_q <= release_d;
                held_q    <= held_d;
            end
        end

        assign b_press[g]   = press_q;
        assign b_rpt[g]     = rpt_q;
        assign b_release[g] = release_q;
        assign b_held[g]    = held_q;
    end

endmodule
